seq_mul32: RTL and testbench
============================

// Module: seq_mul32
// PURPOSE
//  Unsigned 32x32->64 shift-and-add multiplier; one add per clock through a 32-bit ripple adder.
//  Sits downstream of the catalog adder32 and consumes its sum/carry_out every iteration.
//  Valid/ready on both sides; multi-cycle datapath element for the ALU/multiply unit.
// PARAMETERS
//  WIDTH  32                   operand width; product is 2*WIDTH (only 32 supported with adder32)
//  CNT_W  $clog2(WIDTH)+1 = 6  iteration counter width (derived; do not override)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    reset, asynchronous, active-low
//  in_valid   in   1    operands a/b valid
//  in_ready   out  1    block can accept operands
//  a          in   32   multiplicand (unsigned)
//  b          in   32   multiplier (unsigned)
//  out_valid  out  1    product valid
//  out_ready  in   1    consumer accepts product
//  product    out  64   a*b
//  busy       out  1    high while an operation is in flight (BUSY or DONE)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc_hi=0, acc_lo=0, mcand=0, cnt=0.
//   Outputs: in_ready=1, out_valid=0, busy=0, product=0. Takes effect immediately, including mid-operation.
//  States:
//   IDLE: in_ready=1. On in_valid&in_ready: mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0; go to BUSY.
//   BUSY: in_ready=0. Each cycle {c,s}=adder32(acc_hi, acc_lo[0] ? mcand : 0).
//    Update {acc_hi,acc_lo} <= {c,s,acc_lo} >> 1 (the 33rd bit c must be kept); cnt<=cnt+1.
//    When cnt==WIDTH-1 this cycle, go to DONE.
//   DONE: out_valid=1, product={acc_hi,acc_lo}, held stable until out_ready.
//    On out_valid&out_ready go to IDLE.
//  Latency: operand handshake at edge 0; out_valid high after edge WIDTH (32 BUSY cycles).
//   Minimum issue interval is WIDTH+2 cycles: accept, 32 iterations, drain; no overlap.
//  in_valid in BUSY/DONE is ignored (in_ready=0); upstream must hold a/b until accepted.
//  a and b are sampled only at the accept edge; later changes have no effect.
//  product is a register output. It holds the last result in IDLE and reads 0 after reset.
//  Arithmetic: a 32-bit add with carry-out into bit 64 of the shift; the product never overflows 64 bits.
//  Zero operands still take the full 32 iterations (no early termination).
//  No X propagation: unused adder input is driven to 0, never left floating.
// STRUCTURE
//  Package mul_pkg: typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
//   also localparam MUL_WIDTH=32 and MUL_CNT_W=6.
//  One sub-module instance: adder32 (a=acc_hi, b=addend, sum, carry_out) for the iteration add.
//  Everything else (FSM, counter, shift register, handshake) is local to seq_mul32.
//  One always_ff for state/datapath with async reset; one always_comb for next-state and outputs.
// TESTING
//  1 Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, busy=0, product=0.
//  2 a=3, b=5 -> out_valid exactly 32 cycles after accept, product=64'h0000_0000_0000_000F.
//  3 a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 (checks the carry path).
//  4 a=7, b=6 with out_ready=0 for 10 cycles after DONE, in_valid pulsed meanwhile
//    -> product=42, held stable; no second accept; after out_ready=1 one cycle, back to IDLE.
//  5 rst_n low at iteration 10 of a=9, b=9 -> immediate IDLE, out_valid=0;
//    then a=12, b=12 -> product=144.
//  6 Back-to-back: a=32'h8000_0000, b=2 -> 64'h0000_0001_0000_0000;
//    then a=0, b=32'h1234 -> product=0 after the full 32 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder with carry-out; one iteration add of the multiplier.
module adder32
    import mul_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    output logic [MUL_WIDTH-1:0] sum,
    output logic                 carry_out
);

    logic w_carry;

    always_comb begin
        w_carry = 1'b0;
        sum     = '0;
        for (int i = 0; i < int'(MUL_WIDTH); i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        carry_out = w_carry;
    end

endmodule

// File: rtl/seq_mul32.sv
// Unsigned 32x32->64 shift-and-add multiplier, one ripple add per clock,
// valid/ready handshake on operand and product sides.
module seq_mul32
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned CNT_W = MUL_CNT_W;

    mul_state_t       r_state;
    mul_state_t       w_state_d;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    // Addend forced to zero rather than left undriven when the multiplier bit is clear.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    adder32 u_adder32 (
        .a         (r_acc_hi),
        .b         (w_addend),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_d = BUSY;
            end
            BUSY: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) w_state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign product = {r_acc_hi, r_acc_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    // Carry-out becomes the top bit of the right-shifted accumulator.
                    r_acc_hi <= {w_carry, w_sum[WIDTH-1:1]};
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul32.sv
// Directed, table-driven bench for seq_mul32 with hand-written multi-cycle corner sequences.
module tb_seq_mul32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    seq_mul32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one operand pair, return cycles from accept edge to out_valid.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
        vecs[3] = '{32'd1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[4] = '{32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE};
        vecs[5] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_product", product, 64'd0);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("vec%0d_product", i), product, vecs[i].exp);
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            drain();
            check($sformatf("vec%0d_idle", i), 64'(in_ready), 64'd1);
            check($sformatf("vec%0d_hold", i), product, vecs[i].exp);
        end

        // Backpressure: product held, in_valid ignored while DONE
        issue(32'd7, 32'd6, lat);
        check("bp_latency", 64'(lat), 64'd32);
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            a        = 32'd99;
            b        = 32'd99;
            @(posedge clk);
            #1;
            check($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("bp_product%0d", k), product, 64'd42);
            check($sformatf("bp_in_ready%0d", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        drain();
        check("bp_back_idle", 64'(in_ready), 64'd1);
        check("bp_out_valid_low", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_second_accept", 64'(busy), 64'd0);
        check("bp_product_kept", product, 64'd42);

        // Asynchronous reset mid-operation
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd9;
        b        = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd12, 32'd12, lat);
        check("arst_next_latency", 64'(lat), 64'd32);
        check("arst_next_product", product, 64'd144);
        drain();

        // Back-to-back issue; zero operand still runs all iterations
        issue(32'h8000_0000, 32'd2, lat);
        check("b2b0_latency", 64'(lat), 64'd32);
        check("b2b0_product", product, 64'h0000_0001_0000_0000);
        drain();
        issue(32'd0, 32'h1234, lat);
        check("b2b1_latency", 64'(lat), 64'd32);
        check("b2b1_product", product, 64'd0);
        drain();
        check("b2b1_idle", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
